// File: rtl/bus_interface.sv
// External memory bus sequencer: latches an address, runs one read or write cycle
// (stretched by RDY), and hands read data to the data latch with a one-cycle strobe.
module bus_interface #(
  parameter logic [7:0] WAIT_LIMIT = 8'd255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        RW,
  input  logic [7:0]  ADL_IN,
  input  logic [7:0]  ADH_IN,
  input  logic [7:0]  DB_IN,
  input  logic        RDY,
  input  logic [7:0]  MEM_DATA,
  output logic [15:0] ADDR,
  output logic        R_W,
  output logic [7:0]  DATA_OUT,
  output logic        DATA_OE,
  output logic        BUSY,
  output logic        DONE,
  output logic        DL_LOAD,
  output logic [7:0]  DL_DATA,
  output logic        TIMEOUT
);

  typedef enum logic [1:0] {StIdle, StAddr, StAccess, StComplete} state_e;

  state_e      state_q;
  logic [15:0] addr_lat_q;
  logic        rw_lat_q;
  logic [7:0]  db_lat_q;
  logic [7:0]  wait_cnt_q;
  logic        rd_ok_q;

  logic [15:0] addr_q;
  logic        r_w_q;
  logic [7:0]  data_out_q;
  logic        data_oe_q;
  logic        busy_q;
  logic        done_q;
  logic        dl_load_q;
  logic [7:0]  dl_data_q;
  logic        timeout_q;

  logic [7:0]  wait_cnt_inc;
  logic        wait_expired;

  // Saturating increment so a long stall with the timeout disabled never wraps.
  always_comb begin
    wait_cnt_inc = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
    wait_expired = (WAIT_LIMIT != 8'd0) && (wait_cnt_inc >= WAIT_LIMIT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      addr_lat_q <= 16'h0000;
      rw_lat_q   <= 1'b1;
      db_lat_q   <= 8'h00;
      wait_cnt_q <= 8'h00;
      rd_ok_q    <= 1'b0;
      addr_q     <= 16'h0000;
      r_w_q      <= 1'b1;
      data_out_q <= 8'h00;
      data_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dl_load_q  <= 1'b0;
      dl_data_q  <= 8'h00;
      timeout_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      dl_load_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (START) begin
            addr_lat_q <= {ADH_IN, ADL_IN};
            rw_lat_q   <= RW;
            db_lat_q   <= DB_IN;
            state_q    <= StAddr;
          end
        end
        StAddr: begin
          addr_q     <= addr_lat_q;
          r_w_q      <= rw_lat_q;
          data_out_q <= db_lat_q;
          data_oe_q  <= ~rw_lat_q;
          busy_q     <= 1'b1;
          wait_cnt_q <= 8'h00;
          state_q    <= StAccess;
        end
        StAccess: begin
          if (RDY) begin
            if (rw_lat_q) dl_data_q <= MEM_DATA;
            rd_ok_q   <= rw_lat_q;
            r_w_q     <= 1'b1;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= StComplete;
          end else begin
            wait_cnt_q <= wait_cnt_inc;
            if (wait_expired) begin
              // Aborted cycle: no latch load, sticky flag raised.
              timeout_q <= 1'b1;
              rd_ok_q   <= 1'b0;
              r_w_q     <= 1'b1;
              data_oe_q <= 1'b0;
              busy_q    <= 1'b0;
              state_q   <= StComplete;
            end
          end
        end
        StComplete: begin
          done_q    <= 1'b1;
          dl_load_q <= rd_ok_q;
          rd_ok_q   <= 1'b0;
          if (START) begin
            // Back-to-back: the new address goes out on the edge leaving COMPLETE.
            addr_lat_q <= {ADH_IN, ADL_IN};
            rw_lat_q   <= RW;
            db_lat_q   <= DB_IN;
            addr_q     <= {ADH_IN, ADL_IN};
            state_q    <= StAddr;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ADDR     = addr_q;
  assign R_W      = r_w_q;
  assign DATA_OUT = data_out_q;
  assign DATA_OE  = data_oe_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign DL_LOAD  = dl_load_q;
  assign DL_DATA  = dl_data_q;
  assign TIMEOUT  = timeout_q;

endmodule

// File: tb/tb_bus_interface.sv
// Directed bench for bus_interface: a default instance plus a WAIT_LIMIT=4 instance
// driven by the same stimulus.
module tb_bus_interface;

  logic        clk;
  logic        rst;
  logic        start;
  logic        rw;
  logic [7:0]  adl;
  logic [7:0]  adh;
  logic [7:0]  db;
  logic        rdy;
  logic [7:0]  mem_data;

  logic [15:0] addr_a, addr_b;
  logic        r_w_a, r_w_b;
  logic [7:0]  data_out_a, data_out_b;
  logic        data_oe_a, data_oe_b;
  logic        busy_a, busy_b;
  logic        done_a, done_b;
  logic        dl_load_a, dl_load_b;
  logic [7:0]  dl_data_a, dl_data_b;
  logic        timeout_a, timeout_b;

  int unsigned n_checks;
  int unsigned n_fails;

  bus_interface dut (
    .CLK      (clk),
    .RST      (rst),
    .START    (start),
    .RW       (rw),
    .ADL_IN   (adl),
    .ADH_IN   (adh),
    .DB_IN    (db),
    .RDY      (rdy),
    .MEM_DATA (mem_data),
    .ADDR     (addr_a),
    .R_W      (r_w_a),
    .DATA_OUT (data_out_a),
    .DATA_OE  (data_oe_a),
    .BUSY     (busy_a),
    .DONE     (done_a),
    .DL_LOAD  (dl_load_a),
    .DL_DATA  (dl_data_a),
    .TIMEOUT  (timeout_a)
  );

  bus_interface #(.WAIT_LIMIT(8'd4)) dut_t (
    .CLK      (clk),
    .RST      (rst),
    .START    (start),
    .RW       (rw),
    .ADL_IN   (adl),
    .ADH_IN   (adh),
    .DB_IN    (db),
    .RDY      (rdy),
    .MEM_DATA (mem_data),
    .ADDR     (addr_b),
    .R_W      (r_w_b),
    .DATA_OUT (data_out_b),
    .DATA_OE  (data_oe_b),
    .BUSY     (busy_b),
    .DONE     (done_b),
    .DL_LOAD  (dl_load_b),
    .DL_DATA  (dl_data_b),
    .TIMEOUT  (timeout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One rising edge; sample and drive 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic r, input logic [15:0] a, input logic [7:0] d);
    rw  = r;
    adh = a[15:8];
    adl = a[7:0];
    db  = d;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1; start = 1'b0; rw = 1'b1; adl = 8'h00; adh = 8'h00; db = 8'h00;
    rdy = 1'b1; mem_data = 8'h00;
    step();
    step();

    // Reset values
    check_eq("rst_addr", {16'h0, addr_a}, 32'h0000);
    check_eq("rst_r_w", {31'h0, r_w_a}, 32'h1);
    check_eq("rst_data_out", {24'h0, data_out_a}, 32'h00);
    check_eq("rst_oe", {31'h0, data_oe_a}, 32'h0);
    check_eq("rst_busy", {31'h0, busy_a}, 32'h0);
    check_eq("rst_done", {31'h0, done_a}, 32'h0);
    check_eq("rst_dl_load", {31'h0, dl_load_a}, 32'h0);
    check_eq("rst_dl_data", {24'h0, dl_data_a}, 32'h00);
    check_eq("rst_timeout", {31'h0, timeout_a}, 32'h0);
    rst = 1'b0;
    step();

    // Basic read at 1234
    set_req(1'b1, 16'h1234, 8'h00);
    mem_data = 8'hAA; rdy = 1'b1; start = 1'b1;
    step();                                   // edge 0
    start = 1'b0; adl = 8'h00; adh = 8'h00;
    step();                                   // edge 1
    check_eq("rd_addr_e1", {16'h0, addr_a}, 32'h1234);
    check_eq("rd_busy_e1", {31'h0, busy_a}, 32'h1);
    check_eq("rd_r_w_e1", {31'h0, r_w_a}, 32'h1);
    step();                                   // edge 2
    check_eq("rd_done_e2", {31'h0, done_a}, 32'h0);
    check_eq("rd_r_w_e2", {31'h0, r_w_a}, 32'h1);
    step();                                   // edge 3
    check_eq("rd_done_e3", {31'h0, done_a}, 32'h1);
    check_eq("rd_load_e3", {31'h0, dl_load_a}, 32'h1);
    check_eq("rd_data_e3", {24'h0, dl_data_a}, 32'hAA);
    check_eq("rd_r_w_e3", {31'h0, r_w_a}, 32'h1);
    step();
    check_eq("rd_done_e4", {31'h0, done_a}, 32'h0);
    check_eq("rd_load_e4", {31'h0, dl_load_a}, 32'h0);
    check_eq("rd_data_hold", {24'h0, dl_data_a}, 32'hAA);

    // Write 5C to FFFE; DB_IN change after acceptance must not matter
    set_req(1'b0, 16'hFFFE, 8'h5C);
    start = 1'b1;
    step();                                   // edge 0
    start = 1'b0; db = 8'h00; rw = 1'b1;
    step();                                   // edge 1
    check_eq("wr_addr", {16'h0, addr_a}, 32'hFFFE);
    check_eq("wr_r_w_acc", {31'h0, r_w_a}, 32'h0);
    check_eq("wr_oe_acc", {31'h0, data_oe_a}, 32'h1);
    check_eq("wr_data_out", {24'h0, data_out_a}, 32'h5C);
    step();                                   // edge 2 -> COMPLETE
    check_eq("wr_r_w_cmp", {31'h0, r_w_a}, 32'h1);
    check_eq("wr_oe_cmp", {31'h0, data_oe_a}, 32'h0);
    step();                                   // edge 3
    check_eq("wr_done", {31'h0, done_a}, 32'h1);
    check_eq("wr_no_load", {31'h0, dl_load_a}, 32'h0);
    check_eq("wr_dl_data_keep", {24'h0, dl_data_a}, 32'hAA);
    step();

    // Read with RDY low for three samples
    set_req(1'b1, 16'h0100, 8'h00);
    mem_data = 8'h3C; rdy = 1'b0; start = 1'b1;
    step();                                   // edge 0
    start = 1'b0;
    step();                                   // edge 1
    step();                                   // edge 2, wait 1
    step();                                   // edge 3, wait 2
    check_eq("st_busy", {31'h0, busy_a}, 32'h1);
    step();                                   // edge 4, wait 3
    rdy = 1'b1;
    step();                                   // edge 5
    check_eq("st_done_e5", {31'h0, done_a}, 32'h0);
    step();                                   // edge 6
    check_eq("st_done_e6", {31'h0, done_a}, 32'h1);
    check_eq("st_data", {24'h0, dl_data_a}, 32'h3C);
    check_eq("st_timeout", {31'h0, timeout_a}, 32'h0);
    check_eq("st_timeout_w4", {31'h0, timeout_b}, 32'h0);
    check_eq("st_done_w4", {31'h0, done_b}, 32'h1);
    step();

    // Timeout on the WAIT_LIMIT=4 instance
    set_req(1'b1, 16'h2000, 8'h00);
    mem_data = 8'h77; rdy = 1'b0; start = 1'b1;
    step();                                   // edge 0
    start = 1'b0;
    step();                                   // edge 1
    step();                                   // edge 2
    step();                                   // edge 3
    step();                                   // edge 4
    check_eq("to_not_yet", {31'h0, timeout_b}, 32'h0);
    step();                                   // edge 5, 4th low sample
    check_eq("to_flag_e5", {31'h0, timeout_b}, 32'h1);
    check_eq("to_done_e5", {31'h0, done_b}, 32'h0);
    step();                                   // edge 6
    check_eq("to_done_e6", {31'h0, done_b}, 32'h1);
    check_eq("to_no_load", {31'h0, dl_load_b}, 32'h0);
    check_eq("to_data_keep", {24'h0, dl_data_b}, 32'h3C);
    check_eq("to_dflt_busy", {31'h0, busy_a}, 32'h1);
    check_eq("to_dflt_done", {31'h0, done_a}, 32'h0);
    rdy = 1'b1;
    step();                                   // edge 7
    step();                                   // edge 8
    check_eq("to_dflt_done_late", {31'h0, done_a}, 32'h1);
    check_eq("to_dflt_data", {24'h0, dl_data_a}, 32'h77);
    check_eq("to_dflt_flag", {31'h0, timeout_a}, 32'h0);
    step();

    // Good read after timeout: flag stays set
    set_req(1'b1, 16'h3000, 8'h00);
    mem_data = 8'h5A; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check_eq("sticky_done", {31'h0, done_b}, 32'h1);
    check_eq("sticky_load", {31'h0, dl_load_b}, 32'h1);
    check_eq("sticky_data", {24'h0, dl_data_b}, 32'h5A);
    check_eq("sticky_flag", {31'h0, timeout_b}, 32'h1);
    step();

    // Back-to-back reads with START held, then a START pulse while busy
    set_req(1'b1, 16'h0010, 8'h00);
    mem_data = 8'h11; start = 1'b1;
    step();                                   // edge 0
    adl = 8'h11;
    step();                                   // edge 1
    check_eq("b2b_addr1", {16'h0, addr_a}, 32'h0010);
    step();                                   // edge 2
    step();                                   // edge 3, second accept
    check_eq("b2b_done1", {31'h0, done_a}, 32'h1);
    check_eq("b2b_data1", {24'h0, dl_data_a}, 32'h11);
    check_eq("b2b_addr2", {16'h0, addr_a}, 32'h0011);
    start = 1'b0; mem_data = 8'h22;
    step();                                   // edge 4
    check_eq("b2b_busy2", {31'h0, busy_a}, 32'h1);
    check_eq("b2b_gap4", {31'h0, done_a}, 32'h0);
    start = 1'b1; adl = 8'h55;
    step();                                   // edge 5, START seen in ACCESS
    start = 1'b0;
    check_eq("b2b_gap5", {31'h0, done_a}, 32'h0);
    step();                                   // edge 6
    check_eq("b2b_done2", {31'h0, done_a}, 32'h1);
    check_eq("b2b_data2", {24'h0, dl_data_a}, 32'h22);
    step();                                   // edge 7
    check_eq("ign_busy7", {31'h0, busy_a}, 32'h0);
    step();                                   // edge 8
    check_eq("ign_busy8", {31'h0, busy_a}, 32'h0);
    check_eq("ign_addr", {16'h0, addr_a}, 32'h0011);

    // Reset during ACCESS of a write
    set_req(1'b0, 16'hABCD, 8'h99);
    rdy = 1'b0; start = 1'b1;
    step();                                   // edge 0
    start = 1'b0;
    step();                                   // edge 1
    check_eq("rw_r_w_acc", {31'h0, r_w_a}, 32'h0);
    check_eq("rw_oe_acc", {31'h0, data_oe_a}, 32'h1);
    rst = 1'b1;
    step();                                   // edge 2
    rst = 1'b0; rdy = 1'b1;
    check_eq("rs_r_w", {31'h0, r_w_a}, 32'h1);
    check_eq("rs_oe", {31'h0, data_oe_a}, 32'h0);
    check_eq("rs_busy", {31'h0, busy_a}, 32'h0);
    check_eq("rs_addr", {16'h0, addr_a}, 32'h0000);
    check_eq("rs_dl_data", {24'h0, dl_data_a}, 32'h00);
    check_eq("rs_timeout_w4", {31'h0, timeout_b}, 32'h0);
    step();
    check_eq("rs_done_a", {31'h0, done_a}, 32'h0);
    check_eq("rs_load_a", {31'h0, dl_load_a}, 32'h0);
    step();
    check_eq("rs_done_b", {31'h0, done_a}, 32'h0);
    check_eq("rs_load_b", {31'h0, dl_load_a}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/bus_interface.md
# bus_interface

External memory bus sequencer for the 6502 core. It latches a 16-bit address from the internal ADL/ADH buses and runs one read or write cycle on the external bus, stretching the cycle while RDY is low. On reads it hands the captured byte to the data latch as a data byte plus a one-cycle load strobe. It sits directly upstream of the data latch: it is the only source of that latch's DATA and LOAD inputs.

## Interface
Parameters:
- WAIT_LIMIT, default 8'd255: maximum number of ACCESS cycles with RDY low before the cycle is aborted. 0 disables the timeout. Legal range 0..255.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  request a bus cycle; sampled only in IDLE and COMPLETE.
- RW  in  1  cycle type: 1 = read, 0 = write. Captured when START is accepted.
- ADL_IN  in  8  address low byte from the ADL bus; captured when START is accepted.
- ADH_IN  in  8  address high byte from the ADH bus; captured when START is accepted.
- DB_IN  in  8  write data from the DB bus; captured when START is accepted.
- RDY  in  1  memory ready; sampled only in ACCESS.
- MEM_DATA  in  8  external read data.
- ADDR  out  16  external address bus, {ADH, ADL}.
- R_W  out  1  external read/write line. Reads 1 except during a write cycle.
- DATA_OUT  out  8  external write data.
- DATA_OE  out  1  external data bus drive enable.
- BUSY  out  1  high in ADDR and ACCESS.
- DONE  out  1  one-cycle pulse marking the end of a cycle, including aborted cycles.
- DL_LOAD  out  1  load strobe to the data latch.
- DL_DATA  out  8  byte presented to the data latch.
- TIMEOUT  out  1  sticky abort flag.

## Operation
- All outputs are registered.
- States are IDLE, ADDR, ACCESS and COMPLETE.
- IDLE:
  - START=1 goes to ADDR and latches ADDR, RW and DB_IN.
  - START=0 stays in IDLE.
- ADDR:
  - ADDR is driven from the latched value.
  - R_W is driven to the latched RW.
  - DATA_OUT is loaded from the latched DB_IN.
  - Wait counter is cleared.
  - Next state is always ACCESS.
- ACCESS:
  - On a write, DATA_OE=1.
  - RDY=1: on a read, MEM_DATA is captured into DL_DATA. Next state is COMPLETE.
  - RDY=0: wait counter increments. When WAIT_LIMIT≠0 and the count reaches WAIT_LIMIT, next state is COMPLETE with abort; TIMEOUT is set and DL_DATA is not updated.
- COMPLETE:
  - DONE=1.
  - DL_LOAD=1 only for a successful read.
  - R_W=1, DATA_OE=0.
  - START=1 goes directly to ADDR, with capture as in IDLE (back-to-back cycles). Otherwise next state is IDLE.
- START while BUSY=1 is ignored; there is no queue.
- ADDR_IN, RW and DB_IN changes after acceptance have no effect.
- ADDR, DATA_OUT and DL_DATA hold their last value in IDLE.
- TIMEOUT stays set until RST.
- The wait counter is 8 bits and saturates; it cannot wrap.

## Timing
- Reset values: ADDR=16'h0000, R_W=1, DATA_OUT=8'h00, DATA_OE=0, BUSY=0, DONE=0, DL_LOAD=0, DL_DATA=8'h00, TIMEOUT=0, state=IDLE.
- RST during any state: after the next edge, state is IDLE with all reset values. No DONE or DL_LOAD is generated for the interrupted cycle.
- RST has priority over START on the same edge.
- Edge numbering for the following items: START is accepted at edge 0.
  - BUSY=1 and ADDR is valid after edge 1.
  - ACCESS begins after edge 1; RDY is sampled at edge 2.
  - With RDY=1 at edge 2, DONE, DL_LOAD and DL_DATA are valid after edge 3, so minimum latency is 3 cycles.
  - Each RDY=0 sample adds one cycle.
- Back-to-back cycles: one transfer per 3 cycles. ADDR changes on the edge that leaves COMPLETE.
- Timeout: DONE follows WAIT_LIMIT consecutive RDY=0 samples in ACCESS.
- DL_LOAD lasts exactly one cycle. DL_DATA is stable in that cycle and stays stable until the next successful read.

## Test plan
- Reset, then read at 16'h1234 with MEM_DATA=8'hAA and RDY=1: ADDR=1234 after edge 1; DONE=1, DL_LOAD=1 and DL_DATA=AA after edge 3; R_W stays 1 throughout.
- Write 8'h5C to 16'hFFFE with RDY=1: R_W=0 in ADDR and ACCESS; DATA_OE=1 with DATA_OUT=5C in ACCESS; DL_LOAD stays 0; R_W=1 and DATA_OE=0 in COMPLETE.
- Read with RDY low for 3 cycles, then high, MEM_DATA=8'h3C: DONE arrives 6 cycles after acceptance; DL_DATA=3C; TIMEOUT=0.
- WAIT_LIMIT=4 with RDY held low: DONE follows the 4th RDY=0 sample; TIMEOUT=1; DL_LOAD=0; DL_DATA is unchanged; TIMEOUT stays set through a following good read until RST.
- START held high for reads at 0010 then 0011: two DONE pulses 3 cycles apart. A START pulse during BUSY is ignored.
- RST asserted in ACCESS during a write: after the next edge R_W=1, DATA_OE=0, BUSY=0, ADDR=0000, and no DONE or DL_LOAD is produced.
